serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor: computes diff = a - b, LSB first, one bit per clock.
- Each step uses a full-subtractor cell: difference and borrow from one a-bit, one b-bit and the running borrow.
- Inverse-operation companion to the team's adder cells.
- Used where area matters more than latency; start/busy/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- a  in  WIDTH  minuend; sampled only on an accepted start
- b  in  WIDTH  subtrahend; sampled only on an accepted start
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse; diff/bout are valid and updated
- diff  out  WIDTH  result a - b, modulo 2^WIDTH
- bout  out  1  final borrow; 1 when a < b (unsigned)

Behaviour:
- Reset (rst=1 at a rising edge):
  - Outputs: busy=0, done=0, diff=0, bout=0.
  - Internal state: FSM=IDLE, bit counter=0, borrow=0, operand shift registers cleared.
  - Reset mid-operation aborts the operation: no done pulse, diff/bout forced to 0.
- FSM states: IDLE, RUN.
- IDLE:
  - start=1 at edge E0 latches a and b into shift registers, clears borrow and counter, sets busy=1, moves to RUN.
  - done clears at E0 if it was set.
- RUN, one bit per edge E1..EWIDTH; with x=a_sh[0], y=b_sh[0], br=borrow:
  - d = x ^ y ^ br
  - br_next = (~x & y) | (~(x ^ y) & br)
  - Shift operands right one place; shift d into the result shift register from the MSB end; increment counter.
- Completion at edge EWIDTH:
  - Result shift register copied to diff; bout = br_next.
  - done=1, busy=0, FSM returns to IDLE.
- Latency: start accepted at E0; done high in the cycle after EWIDTH; one operation per WIDTH+1 cycles.
- diff/bout update only at completion; they hold the previous result during RUN and until the next completion.
- done is high for exactly one cycle, then low at the next edge.
- start while busy=1 is ignored; no queuing.
- start=1 in the done cycle (busy=0) is accepted: done drops, new operation begins, previous diff/bout hold until the new completion.
- a/b changes after acceptance have no effect.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Equal operands give diff=0, bout=0.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - Extra output port: ovf, out, 1 bit, signed two's-complement overflow.
  - ovf = (a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB]), computed from the latched operand MSBs.
  - Updated at completion alongside diff; reset value 0; holds between operations.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, start with a=0x5A, b=0x23 -> busy for 8 cycles, done pulse 9 edges after start, diff=0x37, bout=0.
- a=0x00, b=0x01 -> diff=0xFF, bout=1; a=0xA5, b=0xA5 -> diff=0x00, bout=0.
- a=0x80, b=0x01 with SERIAL_SUBTRACTOR_OVF_EN -> diff=0x7F, bout=0, ovf=1; a=0x10, b=0x05 -> ovf=0.
- Operation a=0x10, b=0x05 running; pulse start with a=0xFF, b=0x00 at cycle 3 -> ignored; result diff=0x0B.
- Assert rst at RUN cycle 4 -> next edge busy=0, diff=0, no done pulse. Then start a=0x09, b=0x03 -> diff=0x06.
- start held high continuously with fixed operands a=0x40, b=0x30 -> done pulses every 9 cycles, diff=0x10 each time, busy low only in done cycles.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first) with a start/busy/done handshake.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    output logic             bout,
    output logic             ovf
`else
    output logic             bout
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             x;
    logic             y;
    logic             d;
    logic             br_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // Full-subtractor cell acting on the current LSBs and the running borrow
    always_comb begin
        x       = a_sh[0];
        y       = b_sh[0];
        d       = x ^ y ^ borrow;
        br_next = (~x & y) | (~(x ^ y) & borrow);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    // Result bits enter from the MSB end so bit 0 lands at diff[0]
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res    <= {d, res[WIDTH-1:1]};
                    borrow <= br_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff  <= {d, res[WIDTH-1:1]};
                        bout  <= br_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        ovf   <= (a_msb ^ b_msb) & (a_msb ^ d);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
